// File: rtl/fifo_write_arbiter_if.sv
// Purpose : bundles both requester handshakes and the FIFO write port of the write arbiter.
// Latency : wiring only, no state.
// Backpressure: req/ack per requester; write_full from the FIFO throttles write_increment.
interface fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    // Requester 0 (APB register path)
    logic                  req0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  last0;
    logic                  ack0;

    // Requester 1 (I2C receive shifter)
    logic                  req1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  last1;
    logic                  ack1;

    // FIFO write port
    logic                  write_full;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_increment;

    // Current one-hot grant, 2'b00 when idle
    logic [1:0]            grant;

    // Requesters and FIFO side
    modport master (
        output req0, data0, last0,
        output req1, data1, last1,
        output write_full,
        input  ack0, ack1,
        input  write_data, write_increment, grant
    );

    // Arbiter side
    modport slave (
        input  req0, data0, last0,
        input  req1, data1, last1,
        input  write_full,
        output ack0, ack1,
        output write_data, write_increment, grant
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Purpose : round-robin, burst-limited sharer of the async FIFO write port between two requesters.
// Latency : request seen in IDLE -> grant next edge -> first write that cycle; one word/cycle in a grant.
// Backpressure: write_full holds the grant without writing; acks and write_increment are combinational.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                 write_clk,
    input  logic                 write_reset_n,
    fifo_write_arbiter_if.slave  bus
);

    // State encoding doubles as the one-hot grant so grant is a straight decode.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    // burst_cnt counts words already taken in this grant; the exit fires on the
    // accept that would make it MAX_BURST, so it never needs to wrap.
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t                state;
    state_t                state_nxt;
    logic                  last_served;
    logic [3:0]            burst_cnt;

    logic                  sel_req;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;

    // Route the granted requester onto the common write path.
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        case (state)
            GNT0: begin
                sel_req  = bus.req0;
                sel_last = bus.last0;
                sel_data = bus.data0;
            end
            GNT1: begin
                sel_req  = bus.req1;
                sel_last = bus.last1;
                sel_data = bus.data1;
            end
            default: begin
                sel_req  = 1'b0;
                sel_last = 1'b0;
                sel_data = '0;
            end
        endcase
        // write_full is registered in the FIFO, so gating here is always current
        // and a write can never land on a full FIFO.
        accept = sel_req & ~bus.write_full;
    end

    assign bus.write_increment = accept;
    assign bus.write_data      = accept ? sel_data : '0;
    assign bus.ack0            = accept & (state == GNT0);
    assign bus.ack1            = accept & (state == GNT1);
    assign bus.grant           = state;

    // Next-state: round-robin pick from IDLE, leave a grant on last word,
    // burst limit or withdrawal; every grant is followed by one IDLE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nxt = last_served ? GNT0 : GNT1;
                end else if (bus.req0) begin
                    state_nxt = GNT0;
                end else if (bus.req1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!sel_req) begin
                    state_nxt = IDLE;
                end else if (accept && (sel_last || (burst_cnt == BURST_LAST))) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any burst in progress.
    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fairness and burst bookkeeping: record the winner on grant entry and
    // count accepted words while granted. last_served resets to 1 so port 0
    // wins the first tie.
    always_ff @(posedge write_clk or negedge write_reset_n) begin
        if (!write_reset_n) begin
            last_served <= 1'b1;
            burst_cnt   <= 4'd0;
        end else if ((state == IDLE) && (state_nxt == GNT0)) begin
            last_served <= 1'b0;
            burst_cnt   <= 4'd0;
        end else if ((state == IDLE) && (state_nxt == GNT1)) begin
            last_served <= 1'b1;
            burst_cnt   <= 4'd0;
        end else if (accept) begin
            burst_cnt   <= burst_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus a randomized run, all
// compared against a transaction-level model of the grant rules.
// Requesters and the FIFO are queue-based behavioural models driven off-edge.
module tb_fifo_write_arbiter;
    localparam int DW         = 8;
    localparam int MB         = 4;
    localparam int FIFO_DEPTH = 8;

    logic write_clk     = 1'b0;
    logic write_reset_n = 1'b0;
    always #5 write_clk = ~write_clk;

    fifo_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .write_clk     (write_clk),
        .write_reset_n (write_reset_n),
        .bus           (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Requester word queues, each entry {last, data}; FIFO contents model.
    logic [DW:0]   q0[$];
    logic [DW:0]   q1[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wlog[$];
    int            wcyc[$];
    int            cyc = 0;

    bit hold0, hold1, tb_full, fifo_mode, fifo_full, overflow;
    bit seen_ack0, seen_ack1, seen_inc;
    logic [DW-1:0] seen_data;

    // ---------------- reference model ----------------
    // owner: -1 idle, else the port holding the grant; taken counts words in this grant.
    int m_owner = -1;
    int m_taken = 0;
    int m_prev  = 1;

    always @(posedge write_clk or negedge write_reset_n) begin : model
        bit r;
        bit l;
        if (!write_reset_n) begin
            m_owner = -1;
            m_taken = 0;
            m_prev  = 1;
        end else if (m_owner < 0) begin
            if (bus.req0 === 1'b1 && bus.req1 === 1'b1) m_owner = 1 - m_prev;
            else if (bus.req0 === 1'b1)                 m_owner = 0;
            else if (bus.req1 === 1'b1)                 m_owner = 1;
            if (m_owner >= 0) begin
                m_prev  = m_owner;
                m_taken = 0;
            end
        end else begin
            r = (m_owner == 0) ? bus.req0  : bus.req1;
            l = (m_owner == 0) ? bus.last0 : bus.last1;
            if (!r) begin
                m_owner = -1;
            end else if (bus.write_full !== 1'b1) begin
                m_taken = m_taken + 1;
                if (l || m_taken == MB) m_owner = -1;
            end
        end
    end

    logic [DW+4:0] exp_vec;
    logic [DW+4:0] act_vec;

    always_comb begin
        bit            r;
        bit            acc;
        logic [DW-1:0] d;
        logic [1:0]    g;
        r = 1'b0;
        d = '0;
        g = 2'b00;
        if (m_owner == 0) begin r = bus.req0; d = bus.data0; g = 2'b01; end
        else if (m_owner == 1) begin r = bus.req1; d = bus.data1; g = 2'b10; end
        acc = r && (bus.write_full !== 1'b1);
        exp_vec = {g, acc, acc && (m_owner == 0), acc && (m_owner == 1), (acc ? d : {DW{1'b0}})};
    end

    assign act_vec = {bus.grant, bus.write_increment, bus.ack0, bus.ack1, bus.write_data};

    // ---------------- requester / FIFO drivers ----------------
    always @(negedge write_clk) begin
        seen_ack0 = bus.ack0;
        seen_ack1 = bus.ack1;
        seen_inc  = bus.write_increment;
        seen_data = bus.write_data;
        if (bus.write_increment === 1'b1) begin
            wlog.push_back(bus.write_data);
            wcyc.push_back(cyc);
        end
        cyc++;
    end

    always @(negedge write_reset_n) begin
        seen_ack0 = 1'b0;
        seen_ack1 = 1'b0;
        seen_inc  = 1'b0;
    end

    always @(posedge write_clk) begin : drv
        logic [DW:0] h0;
        logic [DW:0] h1;
        #1;
        if (seen_ack0 && q0.size() > 0) void'(q0.pop_front());
        if (seen_ack1 && q1.size() > 0) void'(q1.pop_front());
        if (fifo_mode && seen_inc) begin
            if (fifo_q.size() >= FIFO_DEPTH) overflow = 1'b1;
            else fifo_q.push_back(seen_data);
        end
        seen_ack0 = 1'b0;
        seen_ack1 = 1'b0;
        seen_inc  = 1'b0;
        fifo_full = (fifo_q.size() >= FIFO_DEPTH);
        bus.write_full = fifo_mode ? fifo_full : tb_full;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        bus.req0  = (q0.size() > 0) && !hold0;
        bus.data0 = h0[DW-1:0];
        bus.last0 = h0[DW];
        bus.req1  = (q1.size() > 0) && !hold1;
        bus.data1 = h1[DW-1:0];
        bus.last1 = h1[DW];
    end

    // ---------------- scenarios ----------------
    task automatic settle();
        @(negedge write_clk);
        q0.delete();
        q1.delete();
        hold0   = 1'b0;
        hold1   = 1'b0;
        tb_full = 1'b0;
        repeat (3) @(negedge write_clk);
        #1;
        wlog.delete();
        wcyc.delete();
    endtask

    task automatic test_reset();
        write_reset_n = 1'b0;
        @(negedge write_clk);
        q0.push_back({1'b1, 8'h5A});
        q1.push_back({1'b1, 8'hC3});
        repeat (2) @(negedge write_clk);
        checks++;
        if (act_vec !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", act_vec);
        end
        write_reset_n = 1'b1;
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b01 || bus.write_data !== 8'h5A || bus.ack0 !== 1'b1) begin
            errors++; $display("FAIL reset_first_tie: grant=%b data=%h ack0=%b want 01/5a/1", bus.grant, bus.write_data, bus.ack0);
        end
        @(negedge write_clk);
        checks++;
        if (act_vec !== exp_vec || bus.grant !== 2'b00) begin
            errors++; $display("FAIL reset_gap: got %h want %h (grant 00)", act_vec, exp_vec);
        end
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b10 || bus.write_data !== 8'hC3) begin
            errors++; $display("FAIL reset_second: grant=%b data=%h want 10/c3", bus.grant, bus.write_data);
        end
        settle();
    endtask

    task automatic test_single();
        logic [7:0] want [3];
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
        @(negedge write_clk);
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b00 || bus.write_increment !== 1'b0) begin
            errors++; $display("FAIL single_req_cycle: grant=%b inc=%b want 00/0", bus.grant, bus.write_increment);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge write_clk);
            checks++;
            if (bus.grant !== 2'b01 || bus.write_increment !== 1'b1 || bus.write_data !== want[i] || act_vec !== exp_vec) begin
                errors++; $display("FAIL single_word%0d: got %h want grant 01 inc 1 data %h", i, act_vec, want[i]);
            end
        end
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b00 || bus.write_increment !== 1'b0) begin
            errors++; $display("FAIL single_end: grant=%b inc=%b want 00/0", bus.grant, bus.write_increment);
        end
        settle();
    endtask

    task automatic test_contention();
        int burst, idx, gap;
        logic [7:0] v;
        @(negedge write_clk);
        write_reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q0.push_back({(i == 7), 8'(i)});
            q1.push_back({(i == 7), 8'(8'h80 + i)});
        end
        repeat (2) @(negedge write_clk);
        write_reset_n = 1'b1;
        repeat (22) begin
            @(negedge write_clk);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL contention_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        #1;
        checks++;
        if (wlog.size() != 16) begin
            errors++; $display("FAIL contention_count: got %0d writes want 16", wlog.size());
        end
        for (int i = 0; i < 16 && i < wlog.size(); i++) begin
            burst = i / 4;
            idx   = (burst / 2) * 4 + (i % 4);
            v     = (burst % 2 == 1) ? 8'(8'h80 + idx) : 8'(idx);
            checks++;
            if (wlog[i] !== v) begin
                errors++; $display("FAIL contention_order[%0d]: got %h want %h", i, wlog[i], v);
            end
            if (i > 0) begin
                gap = wcyc[i] - wcyc[i-1];
                checks++;
                if (gap != ((i % 4 == 0) ? 2 : 1)) begin
                    errors++; $display("FAIL contention_gap[%0d]: got %0d want %0d", i, gap, (i % 4 == 0) ? 2 : 1);
                end
            end
        end
        settle();
    endtask

    task automatic test_full_stall();
        @(negedge write_clk);
        tb_full = 1'b1;
        q1.push_back({1'b1, 8'hA5});
        @(negedge write_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge write_clk);
            checks++;
            if (bus.grant !== 2'b10 || bus.write_increment !== 1'b0 || bus.ack1 !== 1'b0) begin
                errors++; $display("FAIL stall_cycle%0d: grant=%b inc=%b ack1=%b want 10/0/0", i, bus.grant, bus.write_increment, bus.ack1);
            end
        end
        tb_full = 1'b0;
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b10 || bus.write_increment !== 1'b1 || bus.ack1 !== 1'b1 || bus.write_data !== 8'hA5) begin
            errors++; $display("FAIL stall_release: got %h want grant 10 inc 1 ack1 1 data a5", act_vec);
        end
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++; $display("FAIL stall_end: grant=%b want 00", bus.grant);
        end
        settle();
    endtask

    task automatic test_withdraw();
        @(negedge write_clk);
        for (int i = 0; i < 4; i++) q0.push_back({1'b0, 8'(8'h31 + i)});
        @(negedge write_clk);
        @(negedge write_clk);
        checks++;
        if (bus.write_data !== 8'h31 || bus.ack0 !== 1'b1) begin
            errors++; $display("FAIL withdraw_w1: data=%h ack0=%b want 31/1", bus.write_data, bus.ack0);
        end
        @(negedge write_clk);
        checks++;
        if (bus.write_data !== 8'h32 || bus.ack0 !== 1'b1) begin
            errors++; $display("FAIL withdraw_w2: data=%h ack0=%b want 32/1", bus.write_data, bus.ack0);
        end
        hold0 = 1'b1;
        q1.push_back({1'b1, 8'h77});
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b01 || bus.write_increment !== 1'b0 || bus.ack0 !== 1'b0) begin
            errors++; $display("FAIL withdraw_nowrite: grant=%b inc=%b ack0=%b want 01/0/0", bus.grant, bus.write_increment, bus.ack0);
        end
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b00) begin
            errors++; $display("FAIL withdraw_idle: grant=%b want 00", bus.grant);
        end
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b10 || bus.write_data !== 8'h77 || bus.ack1 !== 1'b1) begin
            errors++; $display("FAIL withdraw_port1: grant=%b data=%h want 10/77", bus.grant, bus.write_data);
        end
        settle();
    endtask

    task automatic test_reset_mid_burst();
        @(negedge write_clk);
        for (int i = 0; i < 4; i++) q1.push_back({1'b0, 8'(8'h90 + i)});
        repeat (3) @(negedge write_clk);
        checks++;
        if (bus.ack1 !== 1'b1 || bus.write_data !== 8'h91) begin
            errors++; $display("FAIL rstmid_pre: ack1=%b data=%h want 1/91", bus.ack1, bus.write_data);
        end
        #2;
        write_reset_n = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 2'b00 || bus.write_increment !== 1'b0 || bus.ack1 !== 1'b0) begin
            errors++; $display("FAIL rstmid_now: grant=%b inc=%b ack1=%b want 00/0/0", bus.grant, bus.write_increment, bus.ack1);
        end
        q0.push_back({1'b1, 8'hE0});
        @(negedge write_clk);
        write_reset_n = 1'b1;
        @(negedge write_clk);
        checks++;
        if (bus.grant !== 2'b01 || bus.write_data !== 8'hE0) begin
            errors++; $display("FAIL rstmid_port0_first: grant=%b data=%h want 01/e0", bus.grant, bus.write_data);
        end
        settle();
    endtask

    task automatic test_fifo_integration();
        fifo_q.delete();
        overflow  = 1'b0;
        fifo_mode = 1'b1;
        for (int i = 0; i < 12; i++) q0.push_back({(i == 11), 8'(8'h40 + i)});
        repeat (30) begin
            @(negedge write_clk);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL fifo_cycle: got %h want %h", act_vec, exp_vec);
            end
        end
        #1;
        checks++;
        if (wlog.size() != 8) begin
            errors++; $display("FAIL fifo_writes: got %0d want 8", wlog.size());
        end
        checks++;
        if (bus.write_full !== 1'b1 || overflow) begin
            errors++; $display("FAIL fifo_full: full=%b overflow=%b want 1/0", bus.write_full, overflow);
        end
        checks++;
        if (bus.grant !== 2'b01 || bus.write_increment !== 1'b0) begin
            errors++; $display("FAIL fifo_hold: grant=%b inc=%b want 01/0", bus.grant, bus.write_increment);
        end
        for (int i = 0; i < 8 && i < fifo_q.size(); i++) begin
            checks++;
            if (fifo_q[i] !== 8'(8'h40 + i)) begin
                errors++; $display("FAIL fifo_drain[%0d]: got %h want %h", i, fifo_q[i], 8'(8'h40 + i));
            end
        end
        fifo_q.delete();
        repeat (15) begin
            @(negedge write_clk);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL fifo_resume: got %h want %h", act_vec, exp_vec);
            end
        end
        #1;
        checks++;
        if (fifo_q.size() != 4 || overflow) begin
            errors++; $display("FAIL fifo_rest: got %0d words overflow=%b want 4/0", fifo_q.size(), overflow);
        end
        for (int i = 0; i < 4 && i < fifo_q.size(); i++) begin
            checks++;
            if (fifo_q[i] !== 8'(8'h48 + i)) begin
                errors++; $display("FAIL fifo_rest[%0d]: got %h want %h", i, fifo_q[i], 8'(8'h48 + i));
            end
        end
        fifo_mode = 1'b0;
        fifo_q.delete();
        settle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            @(negedge write_clk);
            checks++;
            if (act_vec !== exp_vec) begin
                errors++; $display("FAIL random_cycle%0d: got %h want %h", n, act_vec, exp_vec);
            end
            if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
            if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back({($urandom_range(0, 3) == 0), 8'($urandom)});
            tb_full = ($urandom_range(0, 3) == 0);
            hold0   = ($urandom_range(0, 19) == 0);
            hold1   = ($urandom_range(0, 19) == 0);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_stall();
        test_withdraw();
        test_reset_mid_burst();
        test_fifo_integration();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
